// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline types: writeback source select and load funct3 codes
package pipe_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_CSR = 2'd3
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_ext.sv
// rtl/load_ext.sv - little-endian byte/half lane select with sign or zero extension
module load_ext
  import pipe_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] raw,
  input  logic [1:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] ext
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    case (offset)
      2'd0:    byte_lane = raw[7:0];
      2'd1:    byte_lane = raw[15:8];
      2'd2:    byte_lane = raw[23:16];
      default: byte_lane = raw[31:24];
    endcase
    // offset[0] is ignored for halves; misaligned halves never reach here
    half_lane = offset[1] ? raw[31:16] : raw[15:0];
  end

  always_comb begin
    case (funct3)
      F3_LB:   ext = {{(XLEN-8){byte_lane[7]}}, byte_lane};
      F3_LBU:  ext = {{(XLEN-8){1'b0}}, byte_lane};
      F3_LH:   ext = {{(XLEN-16){half_lane[15]}}, half_lane};
      F3_LHU:  ext = {{(XLEN-16){1'b0}}, half_lane};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MEM/WB pipeline register, writeback select, register file write port and instret
module wb_stage
  import pipe_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int RET_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_valid,
  input  logic             mem_stall,
  input  logic             mem_reg_wr,
  input  logic [4:0]       mem_rd_addr,
  input  logic [1:0]       mem_wb_sel,
  input  logic [2:0]       mem_funct3,
  input  logic [XLEN-1:0]  mem_alu_result,
  input  logic [XLEN-1:0]  mem_load_data,
  input  logic [XLEN-1:0]  mem_pc,
  input  logic [XLEN-1:0]  mem_csr_rdata,
  output logic [4:0]       wr_addr,
  output logic [XLEN-1:0]  data_in,
  output logic             write_en,
  output logic             wb_fwd_en,
  output logic [4:0]       wb_fwd_rd,
  output logic [XLEN-1:0]  wb_fwd_data,
  output logic [RET_W-1:0] instret
);

  logic [XLEN-1:0] load_val;
  logic [XLEN-1:0] wb_val;

  logic            wb_valid;
  logic            wb_reg_wr;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;

  load_ext #(.XLEN(XLEN)) u_load_ext (
    .raw    (mem_load_data),
    .offset (mem_alu_result[1:0]),
    .funct3 (mem_funct3),
    .ext    (load_val)
  );

  always_comb begin
    case (wb_sel_e'(mem_wb_sel))
      WB_ALU:  wb_val = mem_alu_result;
      WB_MEM:  wb_val = load_val;
      WB_PC4:  wb_val = mem_pc + XLEN'(4);
      default: wb_val = mem_csr_rdata;
    endcase
  end

  // a stalled or empty MEM stage hands WB a fully zeroed bubble
  always_ff @(posedge clk) begin
    if (rst || mem_stall || !mem_valid) begin
      wb_valid  <= 1'b0;
      wb_reg_wr <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
    end else begin
      wb_valid  <= 1'b1;
      wb_reg_wr <= mem_reg_wr;
      wb_rd     <= mem_rd_addr;
      wb_data   <= wb_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instret <= '0;
    end else if (wb_valid) begin
      instret <= instret + RET_W'(1);
    end
  end

  assign write_en    = wb_valid & wb_reg_wr & (wb_rd != 5'd0);
  assign wr_addr     = wb_rd;
  assign data_in     = wb_data;
  assign wb_fwd_en   = write_en;
  assign wb_fwd_rd   = wr_addr;
  assign wb_fwd_data = data_in;

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - self-checking bench for wb_stage with vector table, corner sequences and random model
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_stall, mem_reg_wr;
  logic [4:0]  mem_rd_addr;
  logic [1:0]  mem_wb_sel;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_alu_result, mem_load_data, mem_pc, mem_csr_rdata;

  logic [4:0]  wr_addr, wb_fwd_rd, s_wr_addr, s_fwd_rd;
  logic [31:0] data_in, wb_fwd_data, s_data_in, s_fwd_data;
  logic        write_en, wb_fwd_en, s_write_en, s_fwd_en;
  logic [31:0] instret;
  logic [3:0]  s_instret;

  int checks = 0;
  int errors = 0;

  logic        m_valid, m_reg_wr;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic [63:0] m_ret;

  always #5 clk = ~clk;

  wb_stage #(.XLEN(32), .RET_W(32)) dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_stall(mem_stall),
    .mem_reg_wr(mem_reg_wr), .mem_rd_addr(mem_rd_addr), .mem_wb_sel(mem_wb_sel),
    .mem_funct3(mem_funct3), .mem_alu_result(mem_alu_result), .mem_load_data(mem_load_data),
    .mem_pc(mem_pc), .mem_csr_rdata(mem_csr_rdata), .wr_addr(wr_addr), .data_in(data_in),
    .write_en(write_en), .wb_fwd_en(wb_fwd_en), .wb_fwd_rd(wb_fwd_rd),
    .wb_fwd_data(wb_fwd_data), .instret(instret)
  );

  wb_stage #(.XLEN(32), .RET_W(4)) dut_small (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_stall(mem_stall),
    .mem_reg_wr(mem_reg_wr), .mem_rd_addr(mem_rd_addr), .mem_wb_sel(mem_wb_sel),
    .mem_funct3(mem_funct3), .mem_alu_result(mem_alu_result), .mem_load_data(mem_load_data),
    .mem_pc(mem_pc), .mem_csr_rdata(mem_csr_rdata), .wr_addr(s_wr_addr), .data_in(s_data_in),
    .write_en(s_write_en), .wb_fwd_en(s_fwd_en), .wb_fwd_rd(s_fwd_rd),
    .wb_fwd_data(s_fwd_data), .instret(s_instret)
  );

  function automatic logic [31:0] ref_load(input logic [31:0] word, input int a, input int f3);
    logic [31:0] v;
    case (f3)
      0: begin v = (word >> (8 * a)) & 32'hFF; if (v >= 32'd128) v = v - 32'd256; end
      4: v = (word >> (8 * a)) & 32'hFF;
      1: begin v = (word >> (16 * (a / 2))) & 32'hFFFF; if (v >= 32'd32768) v = v - 32'd65536; end
      5: v = (word >> (16 * (a / 2))) & 32'hFFFF;
      default: v = word;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] ref_value();
    case (mem_wb_sel)
      2'd0:    return mem_alu_result;
      2'd1:    return ref_load(mem_load_data, int'(mem_alu_result % 4), int'(mem_funct3));
      2'd2:    return mem_pc + 32'd4;
      default: return mem_csr_rdata;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic compare_all();
    logic exp_we;
    exp_we = m_valid && m_reg_wr && (m_rd != 0);
    check("write_en", {31'd0, write_en}, {31'd0, exp_we});
    check("wr_addr", {27'd0, wr_addr}, {27'd0, m_rd});
    check("data_in", data_in, m_data);
    check("instret", instret, m_ret[31:0]);
    check("instret_w4", {28'd0, s_instret}, {28'd0, m_ret[3:0]});
    check("write_en_w4", {31'd0, s_write_en}, {31'd0, exp_we});
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_reg_wr = 0; m_rd = 0; m_data = 0; m_ret = 0;
    end else begin
      m_ret = m_ret + (m_valid ? 64'd1 : 64'd0);
      if (mem_stall || !mem_valid) begin
        m_valid = 0; m_reg_wr = 0; m_rd = 0; m_data = 0;
      end else begin
        m_valid = 1; m_reg_wr = mem_reg_wr; m_rd = mem_rd_addr; m_data = ref_value();
      end
    end
    #1;
    compare_all();
  endtask

  task automatic set_instr(input logic [4:0] rd, input logic [1:0] sel, input logic [31:0] alu);
    rst = 0; mem_valid = 1; mem_stall = 0; mem_reg_wr = 1;
    mem_rd_addr = rd; mem_wb_sel = sel; mem_alu_result = alu;
  endtask

  always @(negedge clk) begin
    checks++;
    if (wb_fwd_en !== write_en || wb_fwd_rd !== wr_addr || wb_fwd_data !== data_in) begin
      errors++;
      $display("FAIL fwd_mirror: got %b/%h/%h expected %b/%h/%h",
               wb_fwd_en, wb_fwd_rd, wb_fwd_data, write_en, wr_addr, data_in);
    end
  end

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  a;
    logic [31:0] exp;
  } ld_vec_t;

  ld_vec_t tbl [6];
  logic [63:0] base;

  initial begin
    tbl[0] = '{3'b000, 2'd1, 32'h0000007F};
    tbl[1] = '{3'b000, 2'd3, 32'hFFFFFF80};
    tbl[2] = '{3'b100, 2'd2, 32'h000000FF};
    tbl[3] = '{3'b001, 2'd2, 32'hFFFF80FF};
    tbl[4] = '{3'b101, 2'd0, 32'h00007F01};
    tbl[5] = '{3'b010, 2'd0, 32'h80FF7F01};

    rst = 1; mem_valid = 1; mem_stall = 0; mem_reg_wr = 1; mem_rd_addr = 5'd3;
    mem_wb_sel = 0; mem_funct3 = 0; mem_alu_result = 32'hDEADBEEF;
    mem_load_data = 0; mem_pc = 0; mem_csr_rdata = 0;
    step();
    step();
    check("reset_write_en", {31'd0, write_en}, 32'd0);
    check("reset_data_in", data_in, 32'd0);
    check("reset_instret", instret, 32'd0);

    // ALU write, then a bubble so the count becomes visible
    set_instr(5'd5, 2'd0, 32'h12345678);
    step();
    check("alu_write_en", {31'd0, write_en}, 32'd1);
    check("alu_wr_addr", {27'd0, wr_addr}, 32'd5);
    check("alu_data", data_in, 32'h12345678);
    check("alu_instret0", instret, 32'd0);
    mem_valid = 0;
    step();
    check("alu_instret1", instret, 32'd1);

    mem_load_data = 32'h80FF7F01;
    for (int i = 0; i < 6; i++) begin
      set_instr(5'(10 + i), 2'd1, {30'h00001000, tbl[i].a});
      mem_funct3 = tbl[i].f3;
      step();
      check($sformatf("load_ext_%0d", i), data_in, tbl[i].exp);
    end

    set_instr(5'd0, 2'd0, 32'hAAAA5555);
    step();
    check("x0_write_en", {31'd0, write_en}, 32'd0);
    base = m_ret;
    set_instr(5'd1, 2'd2, 32'd0);
    mem_pc = 32'hFFFFFFFC;
    step();
    check("x0_counted", instret, base[31:0] + 32'd1);
    check("pc4_wrap", data_in, 32'h00000000);
    check("pc4_write_en", {31'd0, write_en}, 32'd1);

    // bubble, then three stalled cycles with a valid instruction waiting
    mem_valid = 0;
    step();
    base = m_ret;
    set_instr(5'd9, 2'd3, 32'd0);
    mem_csr_rdata = 32'hC0FFEE00;
    mem_stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_write_en", {31'd0, write_en}, 32'd0);
      check("stall_instret", instret, base[31:0]);
    end
    mem_stall = 0;
    step();
    check("stall_release_data", data_in, 32'hC0FFEE00);
    mem_valid = 0;
    step();
    check("stall_instret_plus1", instret, base[31:0] + 32'd1);

    // same rd back to back: two distinct write cycles in order
    set_instr(5'd4, 2'd0, 32'h00000011);
    step();
    check("b2b_first", data_in, 32'h00000011);
    set_instr(5'd4, 2'd0, 32'h00000022);
    step();
    check("b2b_second", data_in, 32'h00000022);

    set_instr(5'd7, 2'd0, 32'h77777777);
    step();
    check("midflight_captured", {31'd0, write_en}, 32'd1);
    rst = 1;
    step();
    check("midflight_write_en", {31'd0, write_en}, 32'd0);
    check("midflight_instret", instret, 32'd0);

    for (int i = 0; i < 17; i++) begin
      set_instr(5'(i + 1), 2'd0, 32'(i));
      step();
    end
    mem_valid = 0;
    step();
    check("wrap_w4", {28'd0, s_instret}, 32'd1);
    check("wrap_w32", instret, 32'd17);

    for (int i = 0; i < 400; i++) begin
      rst            = ($urandom_range(0, 31) == 0);
      mem_valid      = ($urandom_range(0, 3) != 0);
      mem_stall      = ($urandom_range(0, 3) == 0);
      mem_reg_wr     = ($urandom_range(0, 7) != 0);
      mem_rd_addr    = 5'($urandom);
      mem_wb_sel     = 2'($urandom);
      mem_funct3     = 3'($urandom);
      mem_alu_result = $urandom;
      mem_load_data  = $urandom;
      mem_pc         = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : $urandom;
      mem_csr_rdata  = $urandom;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
